// File: rtl/dcp_dispatch.sv
// ----------------------------------------------------------------------------
// dcp_dispatch - debug control panel command dispatcher
//
// Reads the first character of a command through the SCAN handshake and
// matches it against a table of NCH command codes. It then hands the
// SCAN/PRINT handshakes, debug address and CPU step clock to the matching
// child handler until that handler raises finish. Unknown characters,
// flagged scans and hung handlers are reported over PRINT as the word
// {"E","R",kind,char}. Errors are counted in a saturating 8-bit counter.
//
// Ports
//   clk, rstn                   clock, async active-low reset
//   req_rx/type_rx/ack_rx/      SCAN handshake (char/word mode, done pulse,
//   flag_rx/din_rx              terminator flag, data)
//   req_tx/type_tx/dout_tx/     PRINT handshake
//   ack_tx
//   sel                         one-hot active-channel enable
//   abort                       one-cycle abort pulse to a timed-out channel
//   ch_*                        per-channel handshake, data, address, control
//   addr, clk_cpu               debug address / CPU step clock of the active
//                               channel
//   busy, err_cnt, cs           status: not idle, error count, state code
// ----------------------------------------------------------------------------

// Per-channel code comparator.
module dcp_match (
   input  logic [7:0] code,
   input  logic [7:0] ch,
   output logic       hit
);
   assign hit = (code == ch);
endmodule

module dcp_dispatch #(
   parameter int                NCH       = 8,
   parameter logic [NCH*8-1:0]  CMD_CODES = {"L","G","B","T","P","I","D","R"},
   parameter int                TO_W      = 24,
   parameter logic [TO_W-1:0]   TO_MAX    = 24'hFF_FFFF
) (
   input  logic                  clk,
   input  logic                  rstn,
   // SCAN
   output logic                  req_rx,
   output logic                  type_rx,
   input  logic                  ack_rx,
   input  logic                  flag_rx,
   input  logic [31:0]           din_rx,
   // PRINT
   output logic                  req_tx,
   output logic                  type_tx,
   output logic [31:0]           dout_tx,
   input  logic                  ack_tx,
   // children
   output logic [NCH-1:0]        sel,
   output logic [NCH-1:0]        abort,
   input  logic [NCH-1:0]        ch_req_rx,
   input  logic [NCH-1:0]        ch_type_rx,
   input  logic [NCH-1:0]        ch_req_tx,
   input  logic [NCH-1:0]        ch_type_tx,
   input  logic [NCH-1:0]        ch_finish,
   input  logic [NCH-1:0]        ch_clk_cpu,
   input  logic [NCH-1:0][31:0]  ch_dout,
   input  logic [NCH-1:0][31:0]  ch_addr,
   // debug bus / status
   output logic [31:0]           addr,
   output logic                  clk_cpu,
   output logic                  busy,
   output logic [7:0]            err_cnt,
   output logic [2:0]            cs
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ_1ST = 3'd1,
      S_RUN     = 3'd2,
      S_ERR     = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              st;
   logic [IW-1:0]       idx;
   logic [7:0]          kind;
   logic [7:0]          chr;
   logic [TO_W-1:0]     wd;

   logic [NCH-1:0][7:0] codes;
   logic [NCH-1:0]      hit;
   logic                any_hit;
   logic [IW-1:0]       hit_idx;
   logic                rx_ok, tx_ok, fin, to_hit;
   logic                unused_din;

   assign codes      = CMD_CODES;
   assign unused_din = ^din_rx[31:8];

   for (genvar g = 0; g < NCH; g++) begin : g_lane
      dcp_match u_match (.code(codes[g]), .ch(din_rx[7:0]), .hit(hit[g]));
   end

   // Lowest matching index wins, so duplicate codes resolve deterministically.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   // Output mux: zero-latency pass-through of the selected channel in RUN.
   always_comb begin
      req_rx  = 1'b0;
      type_rx = 1'b0;
      req_tx  = 1'b0;
      type_tx = 1'b0;
      dout_tx = '0;
      sel     = '0;
      addr    = '0;
      clk_cpu = 1'b0;
      case (st)
         S_REQ_1ST: req_rx = 1'b1;
         S_RUN: begin
            sel     = NCH'(1) << idx;
            req_rx  = ch_req_rx[idx];
            type_rx = ch_type_rx[idx];
            req_tx  = ch_req_tx[idx];
            type_tx = ch_type_tx[idx];
            dout_tx = ch_dout[idx];
            addr    = ch_addr[idx];
            clk_cpu = ch_clk_cpu[idx];
         end
         S_ERR: begin
            req_tx  = 1'b1;
            type_tx = 1'b1;
            dout_tx = {8'h45, 8'h52, kind, chr};
         end
         default: ;
      endcase
   end

   // Acks only count while the matching request is up.
   assign rx_ok  = ack_rx & req_rx;
   assign tx_ok  = ack_tx & req_tx;
   assign fin    = ch_finish[idx];
   assign to_hit = (TO_MAX != '0) && (wd == TO_MAX);
   assign busy   = (st != S_IDLE);
   assign cs     = st;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st      <= S_IDLE;
         idx     <= '0;
         kind    <= '0;
         chr     <= '0;
         wd      <= '0;
         err_cnt <= '0;
         abort   <= '0;
      end else begin
         abort <= '0;
         case (st)
            S_IDLE: st <= S_REQ_1ST;
            S_REQ_1ST: begin
               if (rx_ok) begin
                  chr <= din_rx[7:0];
                  if (flag_rx) begin
                     kind <= 8'h46;
                     st   <= S_ERR;
                  end else if (any_hit) begin
                     idx <= hit_idx;
                     wd  <= '0;
                     st  <= S_RUN;
                  end else begin
                     kind <= 8'h55;
                     st   <= S_ERR;
                  end
               end
            end
            S_RUN: begin
               // Finish beats a simultaneous timeout.
               if (fin) begin
                  st <= S_DONE;
               end else if (to_hit) begin
                  abort <= NCH'(1) << idx;
                  kind  <= 8'h54;
                  chr   <= codes[idx];
                  st    <= S_ERR;
               end else if (rx_ok || tx_ok) begin
                  wd <= '0;
               end else begin
                  wd <= wd + TO_W'(1);
               end
            end
            S_ERR: begin
               if (tx_ok) begin
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                  st <= S_DONE;
               end
            end
            S_DONE:  st <= S_REQ_1ST;
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule
